// File: rtl/fetch_ctrl.sv
// Instruction-fetch sequencer: owns the PC, issues one request at a time to a
// variable-latency instruction memory and hands fetched words to decode.
module fetch_ctrl #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned MAX_WAIT = 15
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        PCsrc,
    input  logic [31:0] branch_addr,
    input  logic        stall,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_valid,
    input  logic [31:0] imem_rdata,
    output logic [31:0] instruction,
    output logic [31:0] pc_out,
    output logic [31:0] new_addr,
    output logic        ins_valid,
    output logic        fetch_fault
);

    localparam int CW = $clog2(MAX_WAIT + 1);
    localparam logic [CW-1:0] LAST_WAIT = CW'(MAX_WAIT - 1);
    localparam logic [31:0] NOP = 32'h0000_0013;

    typedef enum logic [1:0] {
        S_FETCH,
        S_WAIT,
        S_OUT,
        S_FAULT
    } state_t;

    state_t          state_reg, state_next;
    logic [31:0]     pc_reg, pc_next;
    logic [31:0]     instr_reg, instr_next;
    logic [31:0]     pc_out_reg, pc_out_next;
    logic            ins_valid_reg;
    logic            fault_reg, fault_next;
    logic            discard_reg, discard_next;
    logic [CW-1:0]   wait_cnt_reg, wait_cnt_next;
    logic [31:0]     target;

    assign target = branch_addr & ~32'h0000_0003;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= S_FETCH;
            pc_reg        <= RESET_PC;
            instr_reg     <= NOP;
            pc_out_reg    <= RESET_PC;
            ins_valid_reg <= 1'b0;
            fault_reg     <= 1'b0;
            discard_reg   <= 1'b0;
            wait_cnt_reg  <= '0;
        end else begin
            state_reg     <= state_next;
            pc_reg        <= pc_next;
            instr_reg     <= instr_next;
            pc_out_reg    <= pc_out_next;
            ins_valid_reg <= (state_next == S_OUT);
            fault_reg     <= fault_next;
            discard_reg   <= discard_next;
            wait_cnt_reg  <= wait_cnt_next;
        end
    end

    always_comb begin
        state_next    = state_reg;
        pc_next       = pc_reg;
        instr_next    = instr_reg;
        pc_out_next   = pc_out_reg;
        fault_next    = fault_reg;
        discard_next  = discard_reg;
        wait_cnt_next = wait_cnt_reg;
        imem_req      = 1'b0;

        case (state_reg)
            S_FETCH: begin
                // The request always goes out with the current pc; a same-cycle
                // redirect just marks its response as stale.
                imem_req      = 1'b1;
                wait_cnt_next = '0;
                state_next    = S_WAIT;
                if (PCsrc) begin
                    pc_next      = target;
                    discard_next = 1'b1;
                end
            end
            S_WAIT: begin
                wait_cnt_next = wait_cnt_reg + CW'(1);
                if (imem_valid) begin
                    if (discard_reg || PCsrc) begin
                        discard_next = 1'b0;
                        state_next   = S_FETCH;
                        if (PCsrc) pc_next = target;
                    end else begin
                        instr_next  = imem_rdata;
                        pc_out_next = pc_reg;
                        state_next  = S_OUT;
                    end
                end else begin
                    if (PCsrc) begin
                        pc_next      = target;
                        discard_next = 1'b1;
                    end
                    if (wait_cnt_reg == LAST_WAIT) begin
                        fault_next = 1'b1;
                        state_next = S_FAULT;
                    end
                end
            end
            S_OUT: begin
                if (PCsrc) begin
                    pc_next    = target;
                    state_next = S_FETCH;
                end else if (!stall) begin
                    pc_next    = pc_reg + 32'd4;
                    state_next = S_FETCH;
                end
            end
            S_FAULT: begin
                state_next = S_FAULT;
            end
            default: begin
                state_next = S_FETCH;
            end
        endcase
    end

    assign imem_addr   = pc_reg;
    assign instruction = instr_reg;
    assign pc_out      = pc_out_reg;
    assign new_addr    = pc_out_reg + 32'd4;
    assign ins_valid   = ins_valid_reg;
    assign fetch_fault = fault_reg;

endmodule

// File: tb/tb_fetch_ctrl.sv
// Directed cycle-by-cycle bench for fetch_ctrl: a per-cycle vector table for
// streaming/stall/redirect/wrap, then hand-written watchdog and reset sequences.
module tb_fetch_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        PCsrc;
    logic [31:0] branch_addr;
    logic        stall;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_valid;
    logic [31:0] imem_rdata;
    logic [31:0] instruction;
    logic [31:0] pc_out;
    logic [31:0] new_addr;
    logic        ins_valid;
    logic        fetch_fault;

    int checks = 0;
    int failures = 0;

    fetch_ctrl #(.RESET_PC(32'h0), .MAX_WAIT(15)) dut (
        .clk(clk), .rst_n(rst_n), .PCsrc(PCsrc), .branch_addr(branch_addr),
        .stall(stall), .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_valid(imem_valid), .imem_rdata(imem_rdata),
        .instruction(instruction), .pc_out(pc_out), .new_addr(new_addr),
        .ins_valid(ins_valid), .fetch_fault(fetch_fault)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        pcsrc;
        logic [31:0] baddr;
        logic        stl;
        logic        iv;
        logic [31:0] rdata;
        logic        e_req;
        logic [31:0] e_addr;
        logic        e_iv;
        logic [31:0] e_pc;
        logic [31:0] e_instr;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic pcsrc, input logic [31:0] baddr, input logic stl,
                       input logic iv, input logic [31:0] rdata, input logic e_req,
                       input logic [31:0] e_addr, input logic e_iv,
                       input logic [31:0] e_pc, input logic [31:0] e_instr);
        vec_t v;
        v.pcsrc = pcsrc; v.baddr = baddr; v.stl = stl; v.iv = iv; v.rdata = rdata;
        v.e_req = e_req; v.e_addr = e_addr; v.e_iv = e_iv; v.e_pc = e_pc; v.e_instr = e_instr;
        vecs.push_back(v);
    endtask

    task automatic chk(input string name, input int cyc, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s cycle %0d: got %h expected %h", name, cyc, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        PCsrc = 1'b0; branch_addr = 32'h0; stall = 1'b0; imem_valid = 1'b0; imem_rdata = 32'h0;
    endtask

    initial begin
        // c0..c12 streaming + stall, c13..c18 redirect in WAIT, c19..c22 redirect in OUT,
        // c23..c27 redirect in FETCH and wrap, c28..c34 multi-redirect, c35..c39 redirect+valid.
        add(0, 0, 0, 0, 32'h0,        1, 32'h0,        0, 32'h0,        32'h13);
        add(0, 0, 0, 1, 32'hAA000000, 0, 32'h0,        0, 32'h0,        32'h13);
        add(0, 0, 0, 0, 32'h0,        0, 32'h0,        1, 32'h0,        32'hAA000000);
        add(0, 0, 0, 0, 32'h0,        1, 32'h4,        0, 32'h0,        32'hAA000000);
        add(0, 0, 0, 1, 32'hAA000004, 0, 32'h0,        0, 32'h0,        32'hAA000000);
        add(0, 0, 0, 0, 32'h0,        0, 32'h0,        1, 32'h4,        32'hAA000004);
        add(0, 0, 0, 0, 32'h0,        1, 32'h8,        0, 32'h4,        32'hAA000004);
        add(0, 0, 0, 1, 32'hAA000008, 0, 32'h0,        0, 32'h4,        32'hAA000004);
        add(0, 0, 1, 0, 32'h0,        0, 32'h0,        1, 32'h8,        32'hAA000008);
        add(0, 0, 1, 1, 32'hDEADBEEF, 0, 32'h0,        1, 32'h8,        32'hAA000008);
        add(0, 0, 1, 0, 32'h0,        0, 32'h0,        1, 32'h8,        32'hAA000008);
        add(0, 0, 1, 0, 32'h0,        0, 32'h0,        1, 32'h8,        32'hAA000008);
        add(0, 0, 0, 0, 32'h0,        0, 32'h0,        1, 32'h8,        32'hAA000008);
        add(0, 0, 0, 0, 32'h0,        1, 32'hC,        0, 32'h8,        32'hAA000008);
        add(0, 0, 0, 0, 32'h0,        0, 32'h0,        0, 32'h8,        32'hAA000008);
        add(1, 32'h103, 0, 0, 32'h0,  0, 32'h0,        0, 32'h8,        32'hAA000008);
        add(0, 0, 0, 1, 32'hAA00000C, 0, 32'h0,        0, 32'h8,        32'hAA000008);
        add(0, 0, 0, 0, 32'h0,        1, 32'h100,      0, 32'h8,        32'hAA000008);
        add(0, 0, 0, 1, 32'hAA000100, 0, 32'h0,        0, 32'h8,        32'hAA000008);
        add(1, 32'h40, 1, 0, 32'h0,   0, 32'h0,        1, 32'h100,      32'hAA000100);
        add(0, 0, 0, 0, 32'h0,        1, 32'h40,       0, 32'h100,      32'hAA000100);
        add(0, 0, 0, 1, 32'hAA000040, 0, 32'h0,        0, 32'h100,      32'hAA000100);
        add(0, 0, 0, 0, 32'h0,        0, 32'h0,        1, 32'h40,       32'hAA000040);
        add(1, 32'hFFFFFFFE, 0, 0, 0, 1, 32'h44,       0, 32'h40,       32'hAA000040);
        add(0, 0, 0, 1, 32'h0BAD0001, 0, 32'h0,        0, 32'h40,       32'hAA000040);
        add(0, 0, 0, 0, 32'h0,        1, 32'hFFFFFFFC, 0, 32'h40,       32'hAA000040);
        add(0, 0, 0, 1, 32'h11111111, 0, 32'h0,        0, 32'h40,       32'hAA000040);
        add(0, 0, 0, 0, 32'h0,        0, 32'h0,        1, 32'hFFFFFFFC, 32'h11111111);
        add(0, 0, 0, 0, 32'h0,        1, 32'h0,        0, 32'hFFFFFFFC, 32'h11111111);
        add(1, 32'h200, 0, 0, 32'h0,  0, 32'h0,        0, 32'hFFFFFFFC, 32'h11111111);
        add(1, 32'h300, 0, 0, 32'h0,  0, 32'h0,        0, 32'hFFFFFFFC, 32'h11111111);
        add(0, 0, 0, 1, 32'h0BAD0002, 0, 32'h0,        0, 32'hFFFFFFFC, 32'h11111111);
        add(0, 0, 0, 0, 32'h0,        1, 32'h300,      0, 32'hFFFFFFFC, 32'h11111111);
        add(0, 0, 0, 1, 32'h22222222, 0, 32'h0,        0, 32'hFFFFFFFC, 32'h11111111);
        add(0, 0, 0, 0, 32'h0,        0, 32'h0,        1, 32'h300,      32'h22222222);
        add(0, 0, 0, 0, 32'h0,        1, 32'h304,      0, 32'h300,      32'h22222222);
        add(1, 32'h500, 0, 1, 32'h0BAD0003, 0, 32'h0,  0, 32'h300,      32'h22222222);
        add(0, 0, 0, 0, 32'h0,        1, 32'h500,      0, 32'h300,      32'h22222222);
        add(0, 0, 0, 1, 32'h33333333, 0, 32'h0,        0, 32'h300,      32'h22222222);
        add(0, 0, 0, 0, 32'h0,        0, 32'h0,        1, 32'h500,      32'h33333333);

        // Reset values while rst_n is low.
        rst_n = 1'b0;
        idle_inputs();
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_req", -1, 32'(imem_req), 32'h1);
        chk("rst_addr", -1, imem_addr, 32'h0);
        chk("rst_instr", -1, instruction, 32'h13);
        chk("rst_pc_out", -1, pc_out, 32'h0);
        chk("rst_new_addr", -1, new_addr, 32'h4);
        chk("rst_ins_valid", -1, 32'(ins_valid), 32'h0);
        chk("rst_fault", -1, 32'(fetch_fault), 32'h0);

        tick();
        rst_n = 1'b1;
        for (int i = 0; i < vecs.size(); i++) begin
            PCsrc = vecs[i].pcsrc; branch_addr = vecs[i].baddr; stall = vecs[i].stl;
            imem_valid = vecs[i].iv; imem_rdata = vecs[i].rdata;
            @(negedge clk);
            chk("req", i, 32'(imem_req), 32'(vecs[i].e_req));
            if (vecs[i].e_req) chk("addr", i, imem_addr, vecs[i].e_addr);
            chk("ins_valid", i, 32'(ins_valid), 32'(vecs[i].e_iv));
            chk("pc_out", i, pc_out, vecs[i].e_pc);
            chk("new_addr", i, new_addr, vecs[i].e_pc + 32'd4);
            chk("instruction", i, instruction, vecs[i].e_instr);
            chk("fault", i, 32'(fetch_fault), 32'h0);
            $display("vec %0d req=%0b addr=%h ins_valid=%0b pc_out=%h instr=%h",
                     i, imem_req, imem_addr, ins_valid, pc_out, instruction);
            tick();
        end

        // Watchdog: request at 0x504, then 15 silent WAIT cycles.
        idle_inputs();
        @(negedge clk);
        chk("wd_req", 40, 32'(imem_req), 32'h1);
        chk("wd_addr", 40, imem_addr, 32'h504);
        for (int k = 1; k <= 15; k++) begin
            tick();
            @(negedge clk);
            chk("wd_wait_req", 40 + k, 32'(imem_req), 32'h0);
            chk("wd_wait_fault", 40 + k, 32'(fetch_fault), 32'h0);
        end
        tick();
        @(negedge clk);
        chk("wd_fault_set", 56, 32'(fetch_fault), 32'h1);
        $display("watchdog fault=%0b after 15 WAIT cycles", fetch_fault);
        for (int k = 0; k < 4; k++) begin
            tick();
            PCsrc = 1'b1; branch_addr = 32'h80 + 32'(k * 4); stall = k[0];
            imem_valid = 1'b1; imem_rdata = 32'h0BAD0004;
            @(negedge clk);
            chk("fault_hold", 57 + k, 32'(fetch_fault), 32'h1);
            chk("fault_req", 57 + k, 32'(imem_req), 32'h0);
            chk("fault_ins_valid", 57 + k, 32'(ins_valid), 32'h0);
        end
        tick();
        idle_inputs();
        rst_n = 1'b0;
        #1;
        chk("fault_clear", 61, 32'(fetch_fault), 32'h0);
        chk("rst_async_req", 61, 32'(imem_req), 32'h1);
        chk("rst_async_pc_out", 61, pc_out, 32'h0);
        chk("rst_async_instr", 61, instruction, 32'h13);
        $display("reset asserted: fault=%0b pc_out=%h", fetch_fault, pc_out);

        // Reset mid-fetch, then a late response landing in FETCH is ignored.
        tick();
        rst_n = 1'b1;
        @(negedge clk);
        chk("mid_req0", 0, 32'(imem_req), 32'h1);
        tick();
        rst_n = 1'b0;
        #1;
        chk("mid_rst_req", 1, 32'(imem_req), 32'h1);
        chk("mid_rst_addr", 1, imem_addr, 32'h0);
        tick();
        rst_n = 1'b1;
        imem_valid = 1'b1; imem_rdata = 32'h0BAD0005;
        @(negedge clk);
        chk("late_req", 0, 32'(imem_req), 32'h1);
        tick();
        imem_valid = 1'b0;
        @(negedge clk);
        chk("late_ignored", 1, 32'(ins_valid), 32'h0);
        tick();
        imem_valid = 1'b1; imem_rdata = 32'h44444444;
        @(negedge clk);
        chk("lat2_wait", 2, 32'(ins_valid), 32'h0);
        tick();
        idle_inputs();
        @(negedge clk);
        chk("lat2_valid", 3, 32'(ins_valid), 32'h1);
        chk("lat2_instr", 3, instruction, 32'h44444444);
        chk("lat2_pc_out", 3, pc_out, 32'h0);
        $display("post-reset fetch instr=%h pc_out=%h", instruction, pc_out);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
